ob_host_if: RTL
===============

# ob_host_if

Host-side initiator for the order book's command/response protocol. It accepts host requests, stamps each with a unique `ob_pkg::uid_t`, issues them on the `ob` command interface under `cmd_full_r` flow control, and tracks every in-flight UID. It consumes `ob` responses, matches each to its request, and returns a completion with the measured round-trip latency. It sits between the host/bench transaction source and `ob`, as the mirror of `ob`'s command-sink / response-source ends.

## Interface
Parameters:
- `OUTSTANDING_N`, 4: maximum in-flight commands (tracker depth), power of two, 2..16.
- `LAT_W`, 16: width of the timestamp counter and the latency field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_vld`  in  1  host request valid.
- `req_cmd`  in  `ob_pkg::cmd_t`  request; `.uid` is ignored and overwritten.
- `req_rdy`  out  1  request accepted this cycle when `req_vld & req_rdy`.
- `cmd_vld_r`  out  1  registered command valid to `ob`.
- `cmd_r`  out  `ob_pkg::cmd_t`  registered command to `ob`.
- `cmd_full_r`  in  1  `ob` command queue full.
- `rsp_vld`  in  1  `ob` response valid.
- `rsp`  in  `ob_pkg::rsp_t`  `ob` response (uid, status).
- `rsp_accept`  out  1  response consumed when `rsp_vld & rsp_accept`.
- `cpl_vld`  out  1  completion valid to host.
- `cpl_uid`  out  `ob_pkg::uid_t`  completed UID.
- `cpl_status`  out  `ob_pkg::status_t`  status copied from `rsp.status`.
- `cpl_latency`  out  `LAT_W`  cycles from issue to response acceptance.
- `cpl_rdy`  in  1  host consumes completion.
- `inflight`  out  `$clog2(OUTSTANDING_N)+1`  tracker occupancy.
- `err_bad_uid_r`  out  1  sticky: a response arrived with a UID not in flight.

## Operation
- **UID counter:** `uid_t` wide, reset 0, increments by 1 per accepted request, wraps modulo 2^width. Width must exceed `log2(OUTSTANDING_N)`, so no live UID is ever reissued.
- **Request acceptance:** `req_rdy = !cmd_full_r & (inflight != OUTSTANDING_N)`. Occupancy is the registered value; an entry freed in the same cycle is not visible to `req_rdy` until the next cycle.
- **Command issue:** on accept, the next cycle presents `cmd_vld_r=1` with `cmd_r = req_cmd` and `.uid` = current UID. `cmd_vld_r` is a single-cycle pulse per request; otherwise `cmd_vld_r=0` and `cmd_r='0`.
- **Flow-control contract:** `ob` must absorb one command presented the cycle after `cmd_full_r` was sampled low.
- **Tracker:** `OUTSTANDING_N` entries, each FREE or PEND, with fields {uid, ts}.
  - FREE→PEND: on accept. Allocate the lowest-index FREE entry; `ts` = free-running `LAT_W` timestamp counter (reset 0, wraps).
  - PEND→FREE: on a matching response.
- **Response path:** `rsp_accept = !cpl_vld | cpl_rdy`. On `rsp_vld & rsp_accept`, CAM-search the PEND entries for `rsp.uid`:
  - Hit: free the entry; load `cpl_uid/cpl_status`; `cpl_latency = now - ts` modulo 2^`LAT_W`; set `cpl_vld`.
  - Miss: drop the response, set `err_bad_uid_r`, and do not change `cpl_vld`.
- **Completion register:** `cpl_vld` stays held, with stable payload, until `cpl_rdy`.
- **Simultaneous events:** an allocate and a free in the same cycle hit different entries; `inflight` nets ±0.
- **Request-independent ops:** `Op_Nop` and `Op_QryBidAsk` are issued and tracked like any other opcode; every command yields exactly one response.

## Timing
- **Reset values:** `req_rdy` is combinational and is 1 in reset whenever `cmd_full_r=0`. All of the following reset to 0 / '0: `cmd_vld_r`, `cmd_r`, `cpl_vld`, `cpl_uid`, `cpl_status`, `cpl_latency`, `inflight`, `err_bad_uid_r`, the UID counter, the timestamp counter, and all tracker entries (FREE). Only `rst` clears `err_bad_uid_r`.
- **Request to command:** 1 cycle (accept at edge t, `cmd_vld_r` high during t+1).
- **Response to completion:** 1 cycle (accept at edge t, `cpl_vld` high from t+1).
- **Throughput:** 1 request/cycle and 1 response/cycle sustained.
- **Reset mid-operation:** all PEND entries are discarded. Responses arriving after reset for pre-reset UIDs miss and set `err_bad_uid_r`; this is expected and benches must ignore it.

## Structure
- **Add to `ob_pkg`:** `latency_t` (`LAT_W`-bit) and a `tracker_entry_t` struct {vld, uid, ts}.
- **Sub-module `ob_host_tracker`:** entry array, lowest-free allocator, UID CAM lookup returning hit/index/ts, and occupancy count.
- **Top level:** UID counter, timestamp counter, command output register, completion register.

## Test plan
- **Single buy, reset then one request:** one `Op_Buy` (qty 10, price 100) → `cmd_vld_r` one cycle later with uid 0; `ob` responds 5 cycles later → `cpl_uid=0`, `cpl_latency=5`.
- **Tracker full:** `OUTSTANDING_N=4`, 4 requests with no responses → `req_rdy=0`, `inflight=4`. One response frees an entry → `req_rdy=1` the following cycle; the next request gets uid 4.
- **Backpressure:** `cmd_full_r=1` for 10 cycles while `req_vld=1` → no acceptance and no `cmd_vld_r`; the request issues 1 cycle after `cmd_full_r` drops.
- **Out-of-order responses:** uids 0,1,2 are outstanding; responses arrive in order 2,0,1 → completions in that order, each with the correct latency, and `inflight` ends at 0.
- **Unknown UID:** response with uid 7 while none is outstanding → `err_bad_uid_r=1` sticky, no `cpl_vld`, `rsp_accept` held 1.
- **Completion stall and wrap:** `cpl_rdy=0` → `rsp_accept=0` while `cpl_vld` is held. Separately, 2^width(uid_t)+1 requests run back-to-back → the UID wraps to 0 with no false CAM hits.

Source files
------------

// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book command/response types and host tracker types
package ob_pkg;

  localparam int UID_W    = 8;
  localparam int QTY_W    = 16;
  localparam int PRICE_W  = 16;
  localparam int OB_LAT_W = 16;

  typedef logic [UID_W-1:0]    uid_t;
  typedef logic [QTY_W-1:0]    qty_t;
  typedef logic [PRICE_W-1:0]  price_t;
  typedef logic [OB_LAT_W-1:0] latency_t;

  typedef enum logic [2:0] {
    Op_Nop       = 3'd0,
    Op_Buy       = 3'd1,
    Op_Sell      = 3'd2,
    Op_Cancel    = 3'd3,
    Op_QryBidAsk = 3'd4
  } opcode_t;

  typedef enum logic [1:0] {
    St_Ok       = 2'd0,
    St_Reject   = 2'd1,
    St_NotFound = 2'd2,
    St_Err      = 2'd3
  } status_t;

  typedef struct packed {
    opcode_t opcode;
    uid_t    uid;
    qty_t    qty;
    price_t  price;
  } cmd_t;

  typedef struct packed {
    uid_t    uid;
    status_t status;
  } rsp_t;

  typedef struct packed {
    logic     vld;
    uid_t     uid;
    latency_t ts;
  } tracker_entry_t;

endpackage

// File: rtl/ob_host_tracker.sv
// rtl/ob_host_tracker.sv - in-flight UID tracker with lowest-free allocator and UID CAM
module ob_host_tracker
  import ob_pkg::*;
#(
  parameter int N     = 4,
  parameter int LAT_W = 16,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  uid_t             alloc_uid,
  input  logic [LAT_W-1:0] alloc_ts,
  input  logic             lookup,
  input  uid_t             lookup_uid,
  output logic             hit,
  output logic [LAT_W-1:0] hit_ts,
  output logic [CNT_W-1:0] count
);

  logic [N-1:0]     ent_vld;
  uid_t             ent_uid [N];
  logic [LAT_W-1:0] ent_ts  [N];

  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic             match_any;
  logic [IDX_W-1:0] match_idx;
  logic             do_alloc;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_uid[i] == lookup_uid)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  assign hit      = lookup & match_any;
  assign hit_ts   = ent_ts[match_idx];
  assign do_alloc = alloc & free_any;

  // Allocation only targets FREE entries and a hit only targets PEND ones,
  // so a same-cycle alloc and free never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
      count   <= '0;
      for (int i = 0; i < N; i++) begin
        ent_uid[i] <= '0;
        ent_ts[i]  <= '0;
      end
    end else begin
      if (do_alloc) begin
        ent_vld[free_idx] <= 1'b1;
        ent_uid[free_idx] <= alloc_uid;
        ent_ts[free_idx]  <= alloc_ts;
      end
      if (hit) begin
        ent_vld[match_idx] <= 1'b0;
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(hit);
    end
  end

endmodule

// File: rtl/ob_host_if.sv
// rtl/ob_host_if.sv - host-side initiator: UID stamping, command issue, response matching
module ob_host_if
  import ob_pkg::*;
#(
  parameter int OUTSTANDING_N = 4,
  parameter int LAT_W         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_vld,
  input  cmd_t                         req_cmd,
  output logic                         req_rdy,
  output logic                         cmd_vld_r,
  output cmd_t                         cmd_r,
  input  logic                         cmd_full_r,
  input  logic                         rsp_vld,
  input  rsp_t                         rsp,
  output logic                         rsp_accept,
  output logic                         cpl_vld,
  output uid_t                         cpl_uid,
  output status_t                      cpl_status,
  output logic [LAT_W-1:0]             cpl_latency,
  input  logic                         cpl_rdy,
  output logic [$clog2(OUTSTANDING_N):0] inflight,
  output logic                         err_bad_uid_r
);

  localparam int CNT_W = $clog2(OUTSTANDING_N) + 1;

  uid_t             uid_cnt;
  logic [LAT_W-1:0] ts_cnt;
  logic             accept;
  logic             rsp_take;
  logic             trk_hit;
  logic [LAT_W-1:0] trk_ts;
  cmd_t             issue_cmd;

  // Occupancy is the registered count, so a same-cycle free is seen next cycle.
  assign req_rdy    = !cmd_full_r && (inflight != CNT_W'(OUTSTANDING_N));
  assign accept     = req_vld & req_rdy;
  assign rsp_accept = !cpl_vld | cpl_rdy;
  assign rsp_take   = rsp_vld & rsp_accept;

  always_comb begin
    issue_cmd     = req_cmd;
    issue_cmd.uid = uid_cnt;
  end

  ob_host_tracker #(
    .N     (OUTSTANDING_N),
    .LAT_W (LAT_W)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .alloc      (accept),
    .alloc_uid  (uid_cnt),
    .alloc_ts   (ts_cnt),
    .lookup     (rsp_take),
    .lookup_uid (rsp.uid),
    .hit        (trk_hit),
    .hit_ts     (trk_ts),
    .count      (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      uid_cnt       <= '0;
      ts_cnt        <= '0;
      cmd_vld_r     <= 1'b0;
      cmd_r         <= '0;
      cpl_vld       <= 1'b0;
      cpl_uid       <= '0;
      cpl_status    <= St_Ok;
      cpl_latency   <= '0;
      err_bad_uid_r <= 1'b0;
    end else begin
      ts_cnt    <= ts_cnt + 1'b1;
      cmd_vld_r <= accept;
      cmd_r     <= accept ? issue_cmd : '0;
      if (accept) begin
        uid_cnt <= uid_cnt + 1'b1;
      end

      // Payload only moves on a hit; a miss leaves the completion untouched.
      if (trk_hit) begin
        cpl_vld     <= 1'b1;
        cpl_uid     <= rsp.uid;
        cpl_status  <= rsp.status;
        cpl_latency <= ts_cnt - trk_ts;
      end else if (cpl_rdy) begin
        cpl_vld <= 1'b0;
      end

      if (rsp_take && !trk_hit) begin
        err_bad_uid_r <= 1'b1;
      end
    end
  end

endmodule
